// File: rtl/ospi_flash_ctrl_pkg.sv
// Shared definitions for the OSPI flash command sequencer: opcode values,
// controller state encoding and a small opcode helper.
package ospi_ctrl_pkg;

  // Request opcodes as carried on req_op
  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  // Only the reserved opcode is rejected; everything else touches the flash
  function automatic logic isLegalOp(input logic [1:0] op);
    return (op != OP_RSVD);
  endfunction

endpackage

// File: rtl/ospi_flash_ctrl_if.sv
// Bundle of the request, response and flash-port signals around the
// controller. The controller uses the slave view; the surrounding system
// (requesters plus flash model) uses the master view.
interface ospi_flash_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);

  // Two requesters, packed side by side (requester i in slice i)
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [3:0]          req_op;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*LEN_W-1:0]  req_len;
  logic [2*DATA_W-1:0] req_wdata;

  // Shared response channel, tagged with the owning requester
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_last;
  logic                rsp_err;

  // Parallel access port of the flash
  logic                flash_cs_n;
  logic                flash_we;
  logic                flash_re;
  logic                flash_ee;
  logic [ADDR_W-1:0]   flash_addr;
  logic [DATA_W-1:0]   flash_wdata;
  logic [DATA_W-1:0]   flash_rdata;

  logic                busy;

  modport slave (
    input  req_valid, req_op, req_addr, req_len, req_wdata,
    input  rsp_ready, flash_rdata,
    output req_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_last, rsp_err,
    output flash_cs_n, flash_we, flash_re, flash_ee, flash_addr, flash_wdata,
    output busy
  );

  modport master (
    output req_valid, req_op, req_addr, req_len, req_wdata,
    output rsp_ready, flash_rdata,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_last, rsp_err,
    input  flash_cs_n, flash_we, flash_re, flash_ee, flash_addr, flash_wdata,
    input  busy
  );

endinterface

// File: rtl/ospi_flash_ctrl_rr_arb.sv
// Two-way round-robin arbiter. When both requesters are valid the one that
// was not granted last wins; the last-grant register starts at 1 so that
// requester 0 wins the very first contest after reset.
module ospi_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant,
  output logic       o_lastGrant
);

  logic r_lastGrant;

  assign o_lastGrant = r_lastGrant;

  // Pick one valid requester, alternating on contention
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_lastGrant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Remember who won the most recent accepted handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrant <= 1'b1;
    end else if (i_accept) begin
      r_lastGrant <= o_grant[1];
    end
  end

endmodule

// File: rtl/ospi_flash_ctrl.sv
// Command sequencer in front of the OSPI flash parallel port. Accepts byte
// read / write / erase requests from two requesters, serialises them onto
// the flash with chip select and one-cycle enable pulses, and returns
// tagged responses on a shared channel. Everything except req_ready is
// registered.
module ospi_flash_ctrl
  import ospi_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int CS_HOLD = 1
) (
  input logic              clk,
  input logic              reset,
  ospi_flash_ctrl_if.slave bus
);

  localparam int                HOLD_W    = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(CS_HOLD - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  // Sequencer state and transaction context
  state_e              r_state;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_cnt;
  logic [HOLD_W-1:0]   r_hold;

  // Registered outputs
  logic                r_rspValid;
  logic                r_rspId;
  logic [DATA_W-1:0]   r_rspData;
  logic                r_rspLast;
  logic                r_rspErr;
  logic                r_csN;
  logic                r_we;
  logic                r_re;
  logic                r_ee;
  logic [ADDR_W-1:0]   r_flashAddr;
  logic [DATA_W-1:0]   r_flashWdata;
  logic                r_busy;

  // Arbitration and selected-request fields
  logic [1:0]          w_grant;
  logic                w_lastGrant;
  logic                w_gid;
  logic                w_accept;
  logic [1:0]          w_reqOp;
  logic [ADDR_W-1:0]   w_reqAddr;
  logic [LEN_W-1:0]    w_reqLen;
  logic [DATA_W-1:0]   w_reqWdata;

  ospi_rr_arb u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (bus.req_valid),
    .i_accept    (w_accept),
    .o_grant     (w_grant),
    .o_lastGrant (w_lastGrant)
  );

  // Requests are only offered a ready while idle and out of reset
  assign bus.req_ready = (r_state == ST_IDLE && !reset) ? w_grant : 2'b00;
  assign w_accept      = |bus.req_ready;

  // Winner index: on contention the requester not granted last, else the lone valid one
  assign w_gid      = (&bus.req_valid) ? ~w_lastGrant : bus.req_valid[1];
  assign w_reqOp    = w_gid ? bus.req_op[3:2] : bus.req_op[1:0];
  assign w_reqAddr  = w_gid ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
  assign w_reqLen   = w_gid ? bus.req_len[2*LEN_W-1:LEN_W]    : bus.req_len[LEN_W-1:0];
  assign w_reqWdata = w_gid ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];

  assign bus.rsp_valid   = r_rspValid;
  assign bus.rsp_id      = r_rspId;
  assign bus.rsp_data    = r_rspData;
  assign bus.rsp_last    = r_rspLast;
  assign bus.rsp_err     = r_rspErr;
  assign bus.flash_cs_n  = r_csN;
  assign bus.flash_we    = r_we;
  assign bus.flash_re    = r_re;
  assign bus.flash_ee    = r_ee;
  assign bus.flash_addr  = r_flashAddr;
  assign bus.flash_wdata = r_flashWdata;
  assign bus.busy        = r_busy;

  // Sequencer FSM: each branch sets the outputs that the next state shows
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_READ;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_rspValid   <= 1'b0;
      r_rspId      <= 1'b0;
      r_rspData    <= '0;
      r_rspLast    <= 1'b0;
      r_rspErr     <= 1'b0;
      r_csN        <= 1'b1;
      r_we         <= 1'b0;
      r_re         <= 1'b0;
      r_ee         <= 1'b0;
      r_flashAddr  <= '0;
      r_flashWdata <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op         <= w_reqOp;
            r_addr       <= w_reqAddr;
            // Writes are always a single byte; the length field is ignored
            r_cnt        <= (w_reqOp == OP_WRITE) ? '0 : w_reqLen;
            r_flashWdata <= w_reqWdata;
            r_rspId      <= w_gid;
            r_busy       <= 1'b1;
            if (isLegalOp(w_reqOp)) begin
              r_state <= ST_SETUP;
              r_csN   <= 1'b0;
            end else begin
              // Reserved opcode: answer with an error without touching the flash
              r_state    <= ST_RESP;
              r_rspValid <= 1'b1;
              r_rspErr   <= 1'b1;
              r_rspLast  <= 1'b1;
              r_rspData  <= '0;
            end
          end
        end

        ST_SETUP: begin
          r_state     <= ST_EXEC;
          r_flashAddr <= r_addr;
          r_we        <= (r_op == OP_WRITE);
          r_re        <= (r_op == OP_READ);
          r_ee        <= (r_op == OP_ERASE);
        end

        ST_EXEC: begin
          case (r_op)
            OP_WRITE: begin
              r_we       <= 1'b0;
              r_state    <= ST_RESP;
              r_rspValid <= 1'b1;
              r_rspLast  <= 1'b1;
              r_rspData  <= '0;
            end
            OP_READ: begin
              r_re    <= 1'b0;
              r_state <= ST_WAIT;
            end
            OP_ERASE: begin
              if (r_cnt == '0) begin
                r_ee       <= 1'b0;
                r_state    <= ST_RESP;
                r_rspValid <= 1'b1;
                r_rspLast  <= 1'b1;
                r_rspData  <= '0;
              end else begin
                // Keep the erase enable up and walk the address, wrapping at the top
                r_cnt       <= r_cnt - LEN_ONE;
                r_addr      <= r_addr + ADDR_ONE;
                r_flashAddr <= r_addr + ADDR_ONE;
              end
            end
            default: begin
              // Unreachable: reserved opcodes never leave IDLE towards the flash
              r_we    <= 1'b0;
              r_re    <= 1'b0;
              r_ee    <= 1'b0;
              r_csN   <= 1'b1;
              r_state <= ST_HOLD;
              r_hold  <= HOLD_INIT;
            end
          endcase
        end

        ST_WAIT: begin
          // Flash read data is valid one cycle after the read enable
          r_rspData  <= bus.flash_rdata;
          r_rspValid <= 1'b1;
          r_rspLast  <= (r_cnt == '0);
          r_state    <= ST_RESP;
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rspValid <= 1'b0;
            r_rspLast  <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspData  <= '0;
            if (r_op == OP_READ && r_cnt != '0) begin
              // Next byte of the read burst
              r_cnt       <= r_cnt - LEN_ONE;
              r_addr      <= r_addr + ADDR_ONE;
              r_flashAddr <= r_addr + ADDR_ONE;
              r_re        <= 1'b1;
              r_state     <= ST_EXEC;
            end else if (!isLegalOp(r_op)) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_HOLD;
              r_csN   <= 1'b1;
              r_hold  <= HOLD_INIT;
            end
          end
        end

        ST_HOLD: begin
          if (r_hold == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_csN   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ospi_flash_ctrl.sv
// Self-checking bench for ospi_flash_ctrl: a table of single transactions
// with hand-computed responses, then hand-written sequences for a stalled
// read burst, reset during a long erase, and round-robin contention.
module tb_ospi_flash_ctrl;
  import ospi_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ospi_flash_ctrl_if #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) bus ();

  ospi_flash_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .CS_HOLD(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural flash: write/erase on the enable cycle, read data one cycle later
  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.flash_we) mem[bus.flash_addr] <= bus.flash_wdata;
    if (bus.flash_ee) mem[bus.flash_addr] <= 8'hFF;
    if (bus.flash_re) bus.flash_rdata <= mem[bus.flash_addr];
  end

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [7:0]  wdata;
    int          nRsp;
    int          nEn;
    int          rspLat;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [2:0] expEnable(input logic [1:0] op);
    case (op)
      OP_WRITE: return 3'b100;
      OP_READ:  return 3'b010;
      OP_ERASE: return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

  // Present one request, wait for its handshake; returns at the negedge after it
  task automatic applyStimulus(input int id, input logic [1:0] op, input logic [7:0] addr,
                               input logic [3:0] len, input logic [7:0] wdata, output int tHs);
    bit ok;
    ok  = 1'b0;
    tHs = 0;
    @(negedge clk);
    bus.req_op[2*id +: 2]    = op;
    bus.req_addr[8*id +: 8]  = addr;
    bus.req_len[4*id +: 4]   = len;
    bus.req_wdata[8*id +: 8] = wdata;
    bus.req_valid[id]        = 1'b1;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (bus.req_ready[id]) begin
        ok  = 1'b1;
        tHs = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("handshake timeout", 0, 1);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
  endtask

  // Run one table entry and compare enables and responses cycle by cycle
  task automatic runVector(input int idx);
    vec_t       v;
    int         tHs, nRsp, nEn;
    bit         done, csLow;
    logic [7:0] ea;
    v     = vecs[idx];
    nRsp  = 0;
    nEn   = 0;
    done  = 1'b0;
    csLow = 1'b0;
    bus.rsp_ready = 1'b1;
    applyStimulus(int'(v.id), v.op, v.addr, v.len, v.wdata, tHs);
    for (int k = 0; k < 60 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (cyc == tHs + 1) checkOutput($sformatf("v%0d busy", idx), bus.busy, 1);
      if (!bus.flash_cs_n) csLow = 1'b1;
      if (bus.flash_we | bus.flash_re | bus.flash_ee) begin
        if (nEn == 0) checkOutput($sformatf("v%0d enable latency", idx), cyc - tHs, 2);
        checkOutput($sformatf("v%0d enable kind", idx),
                    {bus.flash_we, bus.flash_re, bus.flash_ee}, expEnable(v.op));
        ea = v.addr + nEn[7:0];
        checkOutput($sformatf("v%0d flash_addr", idx), bus.flash_addr, ea);
        if (v.op == OP_WRITE) checkOutput($sformatf("v%0d flash_wdata", idx), bus.flash_wdata, v.wdata);
        nEn++;
      end
      if (bus.rsp_valid) begin
        if (nRsp == 0) checkOutput($sformatf("v%0d rsp latency", idx), cyc - tHs, v.rspLat);
        checkOutput($sformatf("v%0d rsp_id", idx), bus.rsp_id, v.id);
        checkOutput($sformatf("v%0d rsp_err", idx), bus.rsp_err, v.err);
        if (nRsp < 4) checkOutput($sformatf("v%0d rsp_data[%0d]", idx, nRsp), bus.rsp_data, v.data[8*nRsp +: 8]);
        checkOutput($sformatf("v%0d rsp_last[%0d]", idx, nRsp), bus.rsp_last, (nRsp == v.nRsp - 1));
        nRsp++;
        if (bus.rsp_last) done = 1'b1;
      end
    end
    if (!done) checkOutput($sformatf("v%0d transaction timeout", idx), 0, 1);
    checkOutput($sformatf("v%0d response count", idx), nRsp, v.nRsp);
    checkOutput($sformatf("v%0d enable count", idx), nEn, v.nEn);
    checkOutput($sformatf("v%0d cs asserted", idx), csLow, (v.op != OP_RSVD));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          tHs, nRsp, lowCnt, seenCyc, lastHs, reStall, reTotal, eeCount, rspCount;
    int          nGrant, run, minGap, gapCount;
    bit          done, found, seenLow;
    logic [31:0] burstData;
    logic [1:0]  grantExp [4];

    // id, op, addr, len, wdata, nRsp, nEn, rspLat, err, data(byte0 lowest)
    vecs[0] = '{1'b0, OP_WRITE, 8'h10, 4'd0, 8'hA5, 1, 1, 3, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, OP_READ,  8'h10, 4'd0, 8'h00, 1, 1, 4, 1'b0, 32'h0000_00A5};
    vecs[2] = '{1'b0, OP_ERASE, 8'hFE, 4'd2, 8'h00, 1, 3, 5, 1'b0, 32'h0000_0000};
    vecs[3] = '{1'b1, OP_READ,  8'hFE, 4'd2, 8'h00, 3, 3, 4, 1'b0, 32'h00FF_FFFF};
    vecs[4] = '{1'b0, OP_WRITE, 8'h11, 4'd0, 8'h66, 1, 1, 3, 1'b0, 32'h0000_0000};
    vecs[5] = '{1'b1, OP_WRITE, 8'h12, 4'd5, 8'h77, 1, 1, 3, 1'b0, 32'h0000_0000};
    vecs[6] = '{1'b0, OP_RSVD,  8'h33, 4'd0, 8'h00, 1, 0, 1, 1'b1, 32'h0000_0000};
    vecs[7] = '{1'b1, OP_READ,  8'h11, 4'd1, 8'h00, 2, 2, 4, 1'b0, 32'h0000_7766};

    bus.req_valid = 2'b00;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    reset         = 1'b1;

    // Reset state, with a request already waiting to check req_ready stays low
    @(negedge clk);
    bus.req_valid = 2'b01;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset req_ready", bus.req_ready, 2'b00);
    checkOutput("reset flash_cs_n", bus.flash_cs_n, 1);
    checkOutput("reset enables", {bus.flash_we, bus.flash_re, bus.flash_ee}, 3'b000);
    checkOutput("reset rsp", {bus.rsp_valid, bus.rsp_last, bus.rsp_err, bus.rsp_id}, 4'b0000);
    checkOutput("reset rsp_data", bus.rsp_data, 8'h00);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset flash_addr", bus.flash_addr, 8'h00);
    checkOutput("reset flash_wdata", bus.flash_wdata, 8'h00);
    bus.req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) runVector(i);

    // Read burst of 4 bytes with the second response held for 5 cycles
    burstData = 32'h0077_66A5;
    nRsp = 0; lowCnt = 0; seenCyc = -1; lastHs = 0; reStall = 0; reTotal = 0; done = 1'b0;
    bus.rsp_ready = 1'b1;
    applyStimulus(1, OP_READ, 8'h10, 4'd3, 8'h00, tHs);
    for (int k = 0; k < 80 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.flash_re) begin
        reTotal++;
        if (nRsp == 1 && lowCnt > 0) reStall++;
      end
      if (bus.rsp_valid) begin
        if (seenCyc < 0) begin
          seenCyc = cyc;
          if (nRsp == 0) checkOutput("burst first latency", cyc - tHs, 4);
          else checkOutput($sformatf("burst byte%0d spacing", nRsp), cyc - lastHs, 3);
        end
        if (nRsp == 1 && lowCnt < 5) begin
          bus.rsp_ready = 1'b0;
          checkOutput($sformatf("burst stall data c%0d", lowCnt), bus.rsp_data, 8'h66);
          checkOutput($sformatf("burst stall last c%0d", lowCnt), bus.rsp_last, 0);
          lowCnt++;
        end else begin
          bus.rsp_ready = 1'b1;
          checkOutput($sformatf("burst rsp_data[%0d]", nRsp), bus.rsp_data, burstData[8*nRsp +: 8]);
          checkOutput($sformatf("burst rsp_last[%0d]", nRsp), bus.rsp_last, (nRsp == 3));
          checkOutput($sformatf("burst rsp_id[%0d]", nRsp), bus.rsp_id, 1);
          if (bus.rsp_last) done = 1'b1;
          lastHs  = cyc;
          seenCyc = -1;
          nRsp++;
        end
      end
    end
    bus.rsp_ready = 1'b1;
    checkOutput("burst completed", done, 1);
    checkOutput("burst byte count", nRsp, 4);
    checkOutput("burst stall cycles", lowCnt, 5);
    checkOutput("burst re during stall", reStall, 0);
    checkOutput("burst re total", reTotal, 4);

    // Reset asserted while a 16-byte erase is running
    applyStimulus(0, OP_ERASE, 8'h80, 4'd15, 8'h00, tHs);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (bus.flash_ee) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("erase started", found, 1);
    repeat (2) @(negedge clk);
    checkOutput("erase still running", bus.flash_ee, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid-reset flash_cs_n", bus.flash_cs_n, 1);
    checkOutput("mid-reset flash_ee", bus.flash_ee, 0);
    checkOutput("mid-reset rsp_valid", bus.rsp_valid, 0);
    checkOutput("mid-reset busy", bus.busy, 0);
    reset = 1'b0;
    eeCount = 0; rspCount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.flash_ee) eeCount++;
      if (bus.rsp_valid) rspCount++;
    end
    checkOutput("post-reset erase enables", eeCount, 0);
    checkOutput("post-reset responses", rspCount, 0);

    // Both requesters hammer writes; grants must alternate starting with 0
    grantExp[0] = 2'b01; grantExp[1] = 2'b10; grantExp[2] = 2'b01; grantExp[3] = 2'b10;
    nGrant = 0; run = 0; minGap = 1000; gapCount = 0; seenLow = 1'b0;
    @(negedge clk);
    bus.req_op    = {OP_WRITE, OP_WRITE};
    bus.req_addr  = {8'h41, 8'h40};
    bus.req_wdata = {8'h02, 8'h01};
    bus.req_len   = '0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (nGrant == 4) bus.req_valid = 2'b00;
      #1;
      if (bus.flash_cs_n) begin
        run++;
      end else begin
        if (seenLow && run > 0) begin
          gapCount++;
          if (run < minGap) minGap = run;
        end
        run = 0;
        seenLow = 1'b1;
      end
      if (|bus.req_ready && nGrant < 4) begin
        checkOutput($sformatf("grant %0d", nGrant), bus.req_ready, grantExp[nGrant]);
        nGrant++;
      end
    end
    checkOutput("grant count", nGrant, 4);
    checkOutput("cs gap count", gapCount, 3);
    checkOutput("cs gap at least 2", (minGap >= 2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ospi_flash_ctrl.md
# ospi_flash_ctrl

Command sequencer and two-port arbiter in front of the OSPI flash model's parallel access port (write/read/erase enables, address, data, chip select). It accepts byte-level read, write and erase requests from two independent requesters over valid/ready channels. It grants them round-robin and drives chip select and a single-cycle enable pulse per flash byte access. Responses and read data return over one shared response channel tagged with the requester ID.

## Interface
- `ADDR_W`, 8: flash address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 8: flash data width.
- `LEN_W`, 4: burst length field width; a burst covers len+1 bytes.
- `CS_HOLD`, 1: cycles chip select stays high after each transaction (minimum 1).

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  request valid, one bit per requester i.
- `req_ready`  out  2  request accepted; at most one bit high.
- `req_op`  in  4  opcode, requester i at [2i+1:2i].
- `req_addr`  in  2*ADDR_W  start address per requester.
- `req_len`  in  2*LEN_W  burst length minus 1; used by READ and ERASE only.
- `req_wdata`  in  2*DATA_W  write byte per requester.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_data`  out  DATA_W  read byte; 0 for non-read responses.
- `rsp_last`  out  1  final response of the transaction.
- `rsp_err`  out  1  illegal opcode.
- `flash_cs_n`  out  1  flash chip select, active low.
- `flash_we`, `flash_re`, `flash_ee`  out  1 each  flash write, read and erase enables.
- `flash_addr`  out  ADDR_W  flash address.
- `flash_wdata`  out  DATA_W  flash write data.
- `flash_rdata`  in  DATA_W  flash read data; valid the cycle after `flash_re`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Opcodes: READ=0, WRITE=1, ERASE=2, RSVD=3.
- States: IDLE, SETUP, EXEC, WAIT, RESP, HOLD.
- IDLE: the arbiter picks one valid requester and raises its `req_ready` combinationally. A handshake latches op, addr, len, wdata and id.
- Arbitration: round-robin. When both requesters are valid, the one not granted last wins. The last-grant register resets to 1, so requester 0 wins first.
- IDLE to SETUP for a legal op. IDLE to RESP for RSVD, with `rsp_err`=1 and `rsp_last`=1; the flash is never touched and `flash_cs_n` stays high.
- SETUP: `flash_cs_n`=0, all enables low. Next state is EXEC.
- EXEC: exactly one enable is high, matching the op, with `flash_addr` = current address.
  - WRITE goes to RESP.
  - READ goes to WAIT.
  - ERASE stays in EXEC, incrementing the address mod 2^ADDR_W, until len+1 bytes are erased, then goes to RESP.
- WAIT: enables low. `flash_rdata` is registered into `rsp_data`. Next state is RESP.
- RESP: `rsp_valid`=1, and all `rsp_*` outputs are held stable until `rsp_ready`.
  - On handshake, a READ with bytes remaining goes to EXEC with address+1 (mod wrap).
  - Otherwise the next state is HOLD (or IDLE for RSVD).
- `rsp_last` marks the final read byte. WRITE and ERASE produce a single response with `rsp_last`=1.
- `flash_cs_n`=0 in SETUP, EXEC, WAIT, and in RESP of legal ops. It is 1 in IDLE and HOLD.
- HOLD: lasts `CS_HOLD` cycles, then IDLE. No requests are accepted outside IDLE.
- Reset values: `flash_cs_n`=1; all enables, `req_ready`, `rsp_*`, `busy`, `flash_addr` and `flash_wdata` = 0; state = IDLE.
- Reset mid-transaction: the next cycle shows the reset values. Any pending response is dropped and no further flash enable is issued.

## Timing
- All outputs are registered except `req_ready`.
- Request handshake at cycle T:
  - SETUP at T+1.
  - First EXEC at T+2.
  - WRITE response at T+3.
  - READ first `rsp_valid` at T+4.
  - ERASE of n bytes: enables high T+2..T+n+1, response at T+n+2.
- Read bursts: each subsequent byte arrives 3 cycles after the previous response handshake (EXEC, WAIT, RESP).
- Backpressure: `rsp_ready` low holds RESP indefinitely. No new flash access is issued while held.
- Turnaround: back-to-back transactions have at least `CS_HOLD` + 1 cycles of `flash_cs_n` high (HOLD plus IDLE).

## Structure
- Package `ospi_ctrl_pkg` holds the opcode localparams and the state encoding.
- Sub-module `ospi_rr_arb`: 2-way round-robin arbiter with inputs valid[1:0] and accept, and outputs grant[1:0] and the last-grant register.
- Address and length counters plus the FSM live in `ospi_flash_ctrl`.

## Test plan
- Write 0xA5 to 0x10 via requester 0, then read 0x10 via requester 1 -> `flash_we` pulse at T+2; read response at T+4 with `rsp_data`=0xA5, `rsp_id`=1, `rsp_last`=1.
- Erase addr 0xFE, len=2 -> `flash_ee` high for 3 cycles with `flash_addr` 0xFE, 0xFF, 0x00; one response with `rsp_last`=1; subsequent reads of those addresses return 0xFF.
- Both requesters valid continuously with writes -> grants alternate 0,1,0,1; `flash_cs_n` high for ≥2 cycles between transactions.
- Read burst len=3 with `rsp_ready` low for 5 cycles on byte 2 -> `rsp_data` held stable; no `flash_re` during the stall; 4 bytes total, `rsp_last` only on byte 4.
- `req_op`=3 -> `rsp_err`=1 at T+1; `flash_cs_n` never low; no enables.
- `reset` asserted during the EXEC of a 16-byte erase -> next cycle `flash_cs_n`=1, `flash_ee`=0, `rsp_valid`=0, `busy`=0.
